// File: rtl/signed_div_pow2_pipe.sv
// Two-stage elastic pipeline: signed divide by 2^S, quotient truncated toward zero.
// Define SIGNED_DIV_POW2_REM_EN to build the signed remainder output (else down_rem is 0).
module signed_div_pow2_pipe #(
  parameter int unsigned N = 8,
  parameter int unsigned S = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [N-1:0] up_data,
  output logic         down_valid,
  input  logic         down_ready,
  output logic [N-1:0] down_quot,
  output logic [N-1:0] down_rem
);

  // Selects the S low dividend bits; all-zero when S = 0, so no zero-width slice is needed.
  localparam logic [N-1:0] LowMask = {N{1'b1}} >> (N - S);

  logic         s1_ready, s2_ready, s1_load, s2_load;
  logic         s1_valid_q, s1_valid_d;
  logic [N-1:0] s1_fl_q, s1_fl_d;
  logic         s1_neg_q, s1_neg_d;
  logic         s1_frac_q, s1_frac_d;
  logic         s2_valid_q, s2_valid_d;
  logic [N-1:0] quot_q, quot_d;
`ifdef SIGNED_DIV_POW2_REM_EN
  logic [N-1:0] s1_low_q, s1_low_d;
  logic [N-1:0] rem_q, rem_d;
`endif

  always_comb begin
    s2_ready   = !s2_valid_q | down_ready;
    s1_ready   = !s1_valid_q | s2_ready;
    s1_load    = up_valid & s1_ready;
    s2_load    = s1_valid_q & s2_ready;

    s1_valid_d = s1_valid_q;
    s1_fl_d    = s1_fl_q;
    s1_neg_d   = s1_neg_q;
    s1_frac_d  = s1_frac_q;
    s2_valid_d = s2_valid_q;
    quot_d     = quot_q;
`ifdef SIGNED_DIV_POW2_REM_EN
    s1_low_d   = s1_low_q;
    rem_d      = rem_q;
`endif

    if (s1_ready) s1_valid_d = up_valid;
    if (s1_load) begin
      s1_fl_d   = $signed(up_data) >>> S;
      s1_neg_d  = up_data[N-1];
      s1_frac_d = |(up_data & LowMask);
`ifdef SIGNED_DIV_POW2_REM_EN
      s1_low_d  = up_data & LowMask;
`endif
    end

    if (s2_ready) s2_valid_d = s1_valid_q;
    if (s2_load) begin
      // Negative dividend with a nonzero fraction: step the floor result up toward zero.
      quot_d = s1_fl_q + {{(N-1){1'b0}}, s1_neg_q & s1_frac_q};
`ifdef SIGNED_DIV_POW2_REM_EN
      rem_d  = (s1_neg_q & s1_frac_q) ? (s1_low_q | ~LowMask) : s1_low_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_fl_q    <= '0;
      s1_neg_q   <= 1'b0;
      s1_frac_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      quot_q     <= '0;
`ifdef SIGNED_DIV_POW2_REM_EN
      s1_low_q   <= '0;
      rem_q      <= '0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_fl_q    <= s1_fl_d;
      s1_neg_q   <= s1_neg_d;
      s1_frac_q  <= s1_frac_d;
      s2_valid_q <= s2_valid_d;
      quot_q     <= quot_d;
`ifdef SIGNED_DIV_POW2_REM_EN
      s1_low_q   <= s1_low_d;
      rem_q      <= rem_d;
`endif
    end
  end

  assign up_ready   = s1_ready;
  assign down_valid = s2_valid_q;
  assign down_quot  = quot_q;
`ifdef SIGNED_DIV_POW2_REM_EN
  assign down_rem   = rem_q;
`else
  assign down_rem   = '0;
`endif

endmodule

// File: tb/tb_signed_div_pow2_pipe.sv
// Scoreboard bench for signed_div_pow2_pipe: three instances (S = 3, 0, 7) share one stream.
module tb_signed_div_pow2_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       up_valid = 1'b0;
  logic [7:0] up_data = '0;
  logic       down_ready = 1'b1;

  logic       ur [3];
  logic       dv [3];
  logic [7:0] dq [3];
  logic [7:0] dr [3];

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] q0 [$];
  logic [15:0] q1 [$];
  logic [15:0] q2 [$];

  always #5 clk = ~clk;

  signed_div_pow2_pipe #(.N(8), .S(3)) u_dut_s3 (
    .clk(clk), .rst_n(rst_n), .up_valid(up_valid), .up_ready(ur[0]), .up_data(up_data),
    .down_valid(dv[0]), .down_ready(down_ready), .down_quot(dq[0]), .down_rem(dr[0])
  );
  signed_div_pow2_pipe #(.N(8), .S(0)) u_dut_s0 (
    .clk(clk), .rst_n(rst_n), .up_valid(up_valid), .up_ready(ur[1]), .up_data(up_data),
    .down_valid(dv[1]), .down_ready(down_ready), .down_quot(dq[1]), .down_rem(dr[1])
  );
  signed_div_pow2_pipe #(.N(8), .S(7)) u_dut_s7 (
    .clk(clk), .rst_n(rst_n), .up_valid(up_valid), .up_ready(ur[2]), .up_data(up_data),
    .down_valid(dv[2]), .down_ready(down_ready), .down_quot(dq[2]), .down_rem(dr[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int shift_of(input int i);
    return (i == 0) ? 3 : ((i == 1) ? 0 : 7);
  endfunction

  // Reference: SystemVerilog integer division/modulo on the sign-extended dividend.
  function automatic logic [15:0] model(input int s, input logic [7:0] a);
    int ai, d, q, r;
    ai = int'($signed(a));
    d  = 1 << s;
    q  = ai / d;
    r  = ai % d;
`ifndef SIGNED_DIV_POW2_REM_EN
    r  = 0;
`endif
    return {q[7:0], r[7:0]};
  endfunction

  task automatic push(input int i, input logic [15:0] v);
    case (i)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic pop(input int i, output logic [15:0] v, output bit ok);
    ok = 1'b0;
    v  = '0;
    case (i)
      0: if (q0.size() > 0) begin v = q0.pop_front(); ok = 1'b1; end
      1: if (q1.size() > 0) begin v = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin v = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  always @(negedge clk) begin
    logic [15:0] e;
    bit ok;
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        if (dv[i] && down_ready) begin
          pop(i, e, ok);
          if (!ok) check($sformatf("unexpected_out_s%0d", shift_of(i)), 32'd1, 32'd0);
          else begin
            check($sformatf("quot_s%0d", shift_of(i)), 32'(dq[i]), 32'(e[15:8]));
            check($sformatf("rem_s%0d", shift_of(i)), 32'(dr[i]), 32'(e[7:0]));
          end
        end
        if (up_valid && ur[i]) push(i, model(shift_of(i), up_data));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one word and hold it until accepted (bounded), leaving just after the accept edge.
  task automatic send(input logic [7:0] a);
    int guard;
    up_valid = 1'b1;
    up_data  = a;
    guard    = 0;
    @(negedge clk);
    while (!ur[0] && guard < 200) begin
      step();
      @(negedge clk);
      guard++;
    end
    if (!ur[0]) check("accept_timeout", 32'd0, 32'd1);
    step();
  endtask

  task automatic drain();
    int guard;
    up_valid = 1'b0;
    guard    = 0;
    while ((q0.size() + q1.size() + q2.size()) > 0 && guard < 1000) begin
      step();
      guard++;
    end
    check("drain_empty", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] dir [6];
    logic [7:0] bp [4];
    dir = '{8'hF3, 8'hF0, 8'h0D, 8'h00, 8'h7F, 8'h80};
    bp  = '{8'h01, 8'hF7, 8'h28, 8'h9C};

    #2;
    check("rst_down_valid", 32'(dv[0]), 32'd0);
    check("rst_up_ready", 32'(ur[0]), 32'd1);
    check("rst_quot", 32'(dq[0]), 32'd0);
    check("rst_rem", 32'(dr[0]), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Directed values: -13, -16, 13, 0, 127, -128.
    foreach (dir[i]) send(dir[i]);
    drain();

    // Exhaustive sweep, back to back.
    for (int a = 0; a < 256; a++) send(8'(a));
    drain();

    // Backpressure: down_ready low while four words are offered.
    down_ready = 1'b0;
    up_valid   = 1'b1;
    up_data    = bp[0];
    @(negedge clk);
    check("bp_ready_w0", 32'(ur[0]), 32'd1);
    step();
    up_data = bp[1];
    @(negedge clk);
    check("bp_ready_w1", 32'(ur[0]), 32'd1);
    step();
    up_data = bp[2];
    @(negedge clk);
    check("bp_ready_full", 32'(ur[0]), 32'd0);
    check("bp_valid_full", 32'(dv[0]), 32'd1);
    check("bp_quot_held0", 32'(dq[0]), 32'd0);
    step();
    @(negedge clk);
    check("bp_ready_still", 32'(ur[0]), 32'd0);
    check("bp_quot_held1", 32'(dq[0]), 32'd0);
    step();
    step();
    down_ready = 1'b1;
    send(bp[2]);
    send(bp[3]);
    drain();

    // Sweep with random downstream stalls.
    fork
      begin
        for (int a = 0; a < 256; a++) send(8'(a));
        drain();
      end
      begin
        for (int c = 0; c < 700; c++) begin
          step();
          down_ready = ($urandom_range(0, 3) != 0);
        end
        down_ready = 1'b1;
      end
    join_any
    disable fork;
    down_ready = 1'b1;
    drain();

    // Reset with both stages full.
    down_ready = 1'b0;
    up_valid   = 1'b1;
    up_data    = 8'hF3;
    step();
    up_data    = 8'h21;
    step();
    up_valid   = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(dv[0]), 32'd0);
    check("mid_rst_quot", 32'(dq[0]), 32'd0);
    check("mid_rst_rem", 32'(dr[0]), 32'd0);
    check("mid_rst_ready", 32'(ur[0]), 32'd1);
    q0.delete();
    q1.delete();
    q2.delete();
    down_ready = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    up_valid = 1'b1;
    up_data  = 8'hF3;
    step();
    up_valid = 1'b0;
    @(negedge clk);
    check("lat_not_yet", 32'(dv[0]), 32'd0);
    step();
    @(negedge clk);
    check("lat_valid", 32'(dv[0]), 32'd1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
